mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 8;
  localparam logic [19:0] MEM_LSB_DEF = 20'h00000;
  localparam logic [19:0] MEM_MSB_DEF = 20'h7FFFF;

  // Requester index: 0 or 1.
  typedef logic req_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RD_OE,
    WR_LD,
    WR_RW,
    DONE
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational two-way pick; on a tie the requester not granted last wins.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  output req_idx_t   gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sequencing single accesses through an external memory datapath.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 always wins a tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] MEM_LSB = ADDR_W'(MEM_LSB_DEF),
  parameter logic [ADDR_W-1:0] MEM_MSB = ADDR_W'(MEM_MSB_DEF)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [1:0]        REQ,
  input  logic [1:0]        WE,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  output logic [1:0]        ACK,
  output logic              ERR,
  output logic [DATA_W-1:0] RDATA,
  output logic              MEM_CS,
  output logic              MEM_LD_ADDR,
  output logic              MEM_LD_DATA,
  output logic              MEM_OE,
  output logic              MEM_RW,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  // state  | meaning
  // IDLE   | waiting for a request (only after reset release has been seen)
  // ADDR   | chip select, load address into datapath
  // RD_OE  | output enable, RDATA captured at end of cycle
  // WR_LD  | load write data into datapath
  // WR_RW  | write strobe, memory commits on this cycle
  // DONE   | one-cycle ACK to the granted requester, ERR if out of range

  localparam logic [ADDR_W-1:0] SPAN = MEM_MSB - MEM_LSB;

  state_t            state_q, state_d;
  logic              run_q;
  req_idx_t          gnt_q, gnt_d, pick_gnt, last_sel;
  logic              pick_valid, take;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic              sel_we, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W:0]   addr_off;

  logic              cs_q, ld_addr_q, ld_data_q, oe_q, rw_q, err_q;
  logic              cs_d, ld_addr_d, ld_data_d, oe_d, rw_d, err_d;
  logic [1:0]        ack_q, ack_d;

  rr_pick u_rr_pick (
    .req   (REQ),
    .last  (last_sel),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

`ifdef ARB_ROUND_ROBIN_EN
  req_idx_t last_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  last_q <= 1'b1;
    else if (take) last_q <= pick_gnt;
  end

  assign last_sel = last_q;
`else
  assign last_sel = 1'b1;
`endif

  assign sel_we    = pick_gnt ? WE[1]  : WE[0];
  assign sel_addr  = pick_gnt ? ADDR1  : ADDR0;
  assign sel_wdata = pick_gnt ? WDATA1 : WDATA0;

  // Offset from the window base; the borrow bit flags addresses below MEM_LSB.
  assign addr_off = {1'b0, sel_addr} - {1'b0, MEM_LSB};
  assign in_range = !addr_off[ADDR_W] && (addr_off[ADDR_W-1:0] <= SPAN);

  assign take  = (state_q == IDLE) && run_q && pick_valid;
  assign gnt_d = take ? pick_gnt : gnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_q && pick_valid) state_d = in_range ? ADDR : DONE;
      ADDR:    state_d = we_q ? WR_LD : RD_OE;
      RD_OE:   state_d = DONE;
      WR_LD:   state_d = WR_RW;
      WR_RW:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they arrive registered with it.
    cs_d      = state_d inside {ADDR, RD_OE, WR_LD, WR_RW};
    ld_addr_d = (state_d == ADDR);
    oe_d      = (state_d == RD_OE);
    ld_data_d = (state_d == WR_LD);
    rw_d      = (state_d == WR_RW);
    ack_d     = 2'b00;
    if (state_d == DONE) ack_d[gnt_d] = 1'b1;
    err_d     = (state_q == IDLE) && (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cs_q      <= 1'b0;
      ld_addr_q <= 1'b0;
      ld_data_q <= 1'b0;
      oe_q      <= 1'b0;
      rw_q      <= 1'b0;
      ack_q     <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      if (take) begin
        gnt_q   <= pick_gnt;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state_q == RD_OE) rdata_q <= MEM_RDATA;
      cs_q      <= cs_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
      oe_q      <= oe_d;
      rw_q      <= rw_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign ACK         = ack_q;
  assign ERR         = err_q;
  assign RDATA       = rdata_q;
  assign MEM_CS      = cs_q;
  assign MEM_LD_ADDR = ld_addr_q;
  assign MEM_LD_DATA = ld_data_q;
  assign MEM_OE      = oe_q;
  assign MEM_RW      = rw_q;
  assign MEM_ADDR    = addr_q;
  assign MEM_WDATA   = wdata_q;

endmodule
